// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: per-buffer en/clr, PC enable, stall/flush statistics.
// Handles load-use stalls, branch flushes, mul/div freezes and syscall halt/resume.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_dst,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             ex_halt,
    input  logic             mdu_start,
    input  logic             resume,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_MDU  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [3:0]       r_mcnt;
    logic [3:0]       w_mcnt_nxt;
    logic [CNT_W-1:0] r_stall;
    logic [CNT_W-1:0] r_flush;
    logic             w_pc, w_ifid_en, w_ifid_clr, w_idex_en, w_idex_clr;
    logic             w_exmem_en, w_exmem_clr, w_memwb_en, w_halted;
    logic             w_flush_inc, w_stall_inc, w_hazard;

    assign w_hazard = ex_is_load && (ex_dst != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_dst)) ||
                       (id_uses_rt && (id_rt == ex_dst)));

    always_comb begin
        w_pc        = 1'b1;
        w_ifid_en   = 1'b1;
        w_ifid_clr  = 1'b0;
        w_idex_en   = 1'b1;
        w_idex_clr  = 1'b0;
        w_exmem_en  = 1'b1;
        w_exmem_clr = 1'b0;
        w_memwb_en  = 1'b1;
        w_halted    = 1'b0;
        w_flush_inc = 1'b0;
        w_next      = r_state;
        w_mcnt_nxt  = r_mcnt;
        case (r_state)
            S_RUN: begin
                if (ex_halt || mdu_start) begin
                    w_pc        = 1'b0;
                    w_ifid_en   = 1'b0;
                    w_idex_en   = 1'b0;
                    w_exmem_clr = 1'b1;
                    if (ex_halt) begin
                        w_next = S_HALT;
                    end else begin
                        w_next     = S_MDU;
                        w_mcnt_nxt = 4'(MDU_LAT - 2);
                    end
                end else if (ex_branch_taken) begin
                    w_ifid_clr  = 1'b1;
                    w_idex_clr  = 1'b1;
                    w_flush_inc = 1'b1;
                end else if (w_hazard) begin
                    w_pc       = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_clr = 1'b1;
                end
            end
            S_MDU: begin
                if (r_mcnt != 4'd0) begin
                    w_pc        = 1'b0;
                    w_ifid_en   = 1'b0;
                    w_idex_en   = 1'b0;
                    w_exmem_clr = 1'b1;
                    w_mcnt_nxt  = r_mcnt - 4'd1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (resume) begin
                    // Squash the syscall still sitting in EX
                    w_exmem_clr = 1'b1;
                    w_next      = S_RUN;
                end else begin
                    w_pc       = 1'b0;
                    w_ifid_en  = 1'b0;
                    w_idex_en  = 1'b0;
                    w_exmem_en = 1'b0;
                    w_memwb_en = 1'b0;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    assign w_stall_inc = !w_pc && (r_state != S_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_mcnt  <= 4'd0;
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_next;
            r_mcnt  <= w_mcnt_nxt;
            if (w_stall_inc && (r_stall != {CNT_W{1'b1}}))
                r_stall <= r_stall + 1'b1;
            if (w_flush_inc && (r_flush != {CNT_W{1'b1}}))
                r_flush <= r_flush + 1'b1;
        end
    end

    assign pc_en     = rst_n & w_pc;
    assign ifid_en   = rst_n & w_ifid_en;
    assign ifid_clr  = rst_n & w_ifid_clr;
    assign idex_en   = rst_n & w_idex_en;
    assign idex_clr  = rst_n & w_idex_clr;
    assign exmem_en  = rst_n & w_exmem_en;
    assign exmem_clr = rst_n & w_exmem_clr;
    assign memwb_en  = rst_n & w_memwb_en;
    assign halted    = rst_n & w_halted;
    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two parameterisations driven by shared stimulus,
// each compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rs, id_uses_rt, ex_is_load, ex_branch_taken;
    logic       ex_halt, mdu_start, resume;

    logic        a_pc, a_ife, a_ifc, a_ide, a_idc, a_exe, a_exc, a_mwe, a_hlt;
    logic [31:0] a_stall, a_flush;
    logic        b_pc, b_ife, b_ifc, b_ide, b_idc, b_exe, b_exc, b_mwe, b_hlt;
    logic [2:0]  b_stall, b_flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(32)) u_a (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
        .mdu_start(mdu_start), .resume(resume),
        .pc_en(a_pc), .ifid_en(a_ife), .ifid_clr(a_ifc),
        .idex_en(a_ide), .idex_clr(a_idc),
        .exmem_en(a_exe), .exmem_clr(a_exc), .memwb_en(a_mwe),
        .halted(a_hlt), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_hazard_ctrl #(.MDU_LAT(2), .CNT_W(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_dst(ex_dst), .ex_is_load(ex_is_load),
        .ex_branch_taken(ex_branch_taken), .ex_halt(ex_halt),
        .mdu_start(mdu_start), .resume(resume),
        .pc_en(b_pc), .ifid_en(b_ife), .ifid_clr(b_ifc),
        .idex_en(b_ide), .idex_clr(b_idc),
        .exmem_en(b_exe), .exmem_clr(b_exc), .memwb_en(b_mwe),
        .halted(b_hlt), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    // Control vectors: {pc, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en}
    localparam logic [7:0] C_ADV    = 8'b1101_0101;
    localparam logic [7:0] C_FREEZE = 8'b0000_0111;
    localparam logic [7:0] C_BRANCH = 8'b1111_1101;
    localparam logic [7:0] C_LDUSE  = 8'b0001_1101;
    localparam logic [7:0] C_IDLE   = 8'b0000_0000;
    localparam logic [7:0] C_RESUME = 8'b1101_0111;

    int     lat [2]  = '{4, 2};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd7};
    bit     m_halt [2];
    int     m_wait [2];
    longint m_stall [2];
    longint m_flush [2];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit rst, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit [4:0] dst,
                        input bit ld, input bit br, input bit hl,
                        input bit mdu, input bit res);
        logic [7:0] got [2];
        logic       gh [2];
        longint     gs [2];
        longint     gf [2];
        logic [7:0] e;
        bit         eh, hz;
        @(posedge clk);
        #1;
        rst_n = ~rst; id_rs = rs; id_rt = rt; id_uses_rs = urs;
        id_uses_rt = urt; ex_dst = dst; ex_is_load = ld;
        ex_branch_taken = br; ex_halt = hl; mdu_start = mdu; resume = res;
        #4;
        got[0] = {a_pc, a_ife, a_ifc, a_ide, a_idc, a_exe, a_exc, a_mwe};
        got[1] = {b_pc, b_ife, b_ifc, b_ide, b_idc, b_exe, b_exc, b_mwe};
        gh[0] = a_hlt; gh[1] = b_hlt;
        gs[0] = longint'(a_stall); gs[1] = longint'(b_stall);
        gf[0] = longint'(a_flush); gf[1] = longint'(b_flush);
        hz = ld && dst != 0 && ((urs && rs == dst) || (urt && rt == dst));
        for (int k = 0; k < 2; k++) begin
            eh = 1'b0;
            if (rst) begin
                m_halt[k] = 0; m_wait[k] = 0;
                m_stall[k] = 0; m_flush[k] = 0;
                e = C_IDLE;
            end else if (m_halt[k]) begin
                eh = 1'b1;
                e = res ? C_RESUME : C_IDLE;
            end else if (m_wait[k] > 0) begin
                e = (m_wait[k] > 1) ? C_FREEZE : C_ADV;
            end else if (hl || mdu) begin
                e = C_FREEZE;
            end else if (br) begin
                e = C_BRANCH;
            end else if (hz) begin
                e = C_LDUSE;
            end else begin
                e = C_ADV;
            end
            chk($sformatf("ctl%0d", k), 64'(got[k]), 64'(e));
            chk($sformatf("halted%0d", k), 64'(gh[k]), 64'(eh));
            chk($sformatf("stall%0d", k), gs[k], m_stall[k]);
            chk($sformatf("flush%0d", k), gf[k], m_flush[k]);
            if (!rst) begin
                if (!m_halt[k] && !e[7] && m_stall[k] < cmax[k])
                    m_stall[k]++;
                if (m_halt[k]) begin
                    if (res) m_halt[k] = 0;
                end else if (m_wait[k] > 0) begin
                    m_wait[k]--;
                end else if (hl) begin
                    m_halt[k] = 1;
                end else if (mdu) begin
                    m_wait[k] = lat[k] - 1;
                end else if (br && m_flush[k] < cmax[k]) begin
                    m_flush[k]++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; id_rs = '0; id_rt = '0; ex_dst = '0;
        id_uses_rs = 0; id_uses_rt = 0; ex_is_load = 0;
        ex_branch_taken = 0; ex_halt = 0; mdu_start = 0; resume = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs, then same with $zero destination
        step(0, 8, 3, 1, 1, 8, 1, 0, 0, 0, 0);
        step(0, 0, 3, 1, 1, 0, 1, 0, 0, 0, 0);
        step(0, 4, 9, 0, 1, 9, 1, 0, 0, 0, 0);
        // branch beats load-use
        step(0, 8, 3, 1, 1, 8, 1, 1, 0, 0, 0);
        idle(2);
        // mul/div held high
        for (int i = 0; i < 4; i++)
            step(0, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
        idle(3);
        // halt, wait, resume with ex_halt still asserted
        for (int i = 0; i < 4; i++)
            step(0, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
        idle(2);
        // resume in the first HALT cycle, and resume outside HALT
        step(0, 1, 2, 1, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 1);
        // reset in the middle of MDU_WAIT
        step(0, 1, 2, 1, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        // flush saturation on the 3-bit instance
        for (int i = 0; i < 10; i++)
            step(0, 1, 2, 1, 1, 0, 0, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central sequencer for the four inter-stage pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register of the 5-stage MIPS core. Every cycle it computes the `en`/`clr` pair for each buffer and the PC write enable. It resolves load-use stalls, taken-branch flushes, multi-cycle multiply/divide freezes and syscall halt/resume. It also keeps saturating stall and flush statistics counters.

## Interface
Parameters:
- `MDU_LAT`, default 4: total EX-stage cycles of a mul/div instruction; legal range 2..16.
- `CNT_W`, default 32: width of the statistics counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source register numbers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  the ID instruction actually reads that source.
- `ex_dst`  in  5  destination register of the instruction in EX.
- `ex_is_load`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  the EX instruction redirects the PC this cycle.
- `ex_halt`  in  1  the EX instruction is a halting syscall.
- `mdu_start`  in  1  the EX instruction is a mul/div.
- `resume`  in  1  single-cycle pulse that releases HALT.
- `pc_en`  out  1  PC register write enable.
- `ifid_en`, `ifid_clr`, `idex_en`, `idex_clr`, `exmem_en`, `exmem_clr`, `memwb_en`  out  1 each  buffer controls. A buffer with `en`=1 and `clr`=1 loads a bubble (IR and signal zeroed).
- `halted`  out  1  high while in HALT.
- `stall_cnt`  out  CNT_W  count of frozen-front-end cycles.
- `flush_cnt`  out  CNT_W  count of branch flushes.

## Operation
- States: RUN, MDU_WAIT, HALT. A down-counter `mcnt` (4 bit) is used in MDU_WAIT.
- Outputs are Mealy: combinational from the current state and the current inputs.
- **Default advance:** all `*_en`=1 and all `*_clr`=0.
- **Freeze pattern:** `pc_en`=`ifid_en`=`idex_en`=0; `exmem_en`=1 with `exmem_clr`=1; `memwb_en`=1. Older instructions drain and a bubble enters MEM.
- **RUN, priority high to low:**
  1. `ex_halt`: freeze pattern; next state HALT.
  2. `mdu_start`: freeze pattern; `mcnt`<=MDU_LAT-2; next state MDU_WAIT.
  3. `ex_branch_taken`: `pc_en`=1 (target loads); `ifid_en`=`ifid_clr`=1; `idex_en`=`idex_clr`=1; remaining buffers advance. `flush_cnt` increments.
  4. Load-use: `ex_is_load` and `ex_dst`!=0 and ((`id_uses_rs` and `id_rs`==`ex_dst`) or (`id_uses_rt` and `id_rt`==`ex_dst`)). Then `pc_en`=`ifid_en`=0, `idex_en`=`idex_clr`=1, remaining buffers advance.
  5. Otherwise default advance.
- **MDU_WAIT:**
  - `mcnt`!=0: freeze pattern, `mcnt` decrements.
  - `mcnt`==0: default advance; next state RUN.
  - All data inputs (`ex_halt`, `mdu_start`, branch, hazard) are ignored in this state.
- **HALT:**
  - Without `resume`: all `*_en`=0 and `halted`=1.
  - On `resume`: `pc_en`=`ifid_en`=`idex_en`=1, `exmem_en`=`exmem_clr`=1 (the syscall is squashed), `memwb_en`=1, `halted`=1; next state RUN. `ex_halt` is ignored in that cycle.
- **Counters:**
  - `stall_cnt` increments in every cycle with `pc_en`=0 and state!=HALT.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- **Reset:** while `rst_n`=0, all outputs are forced to 0 (every `*_en`=0, `*_clr`=0, `halted`=0). Asynchronously on reset: state<=RUN, `mcnt`<=0, counters<=0. A reset during MDU_WAIT or HALT abandons that state.

## Timing
- Zero-cycle decision latency: controls are valid in the same cycle as the inputs and are sampled by the buffers at the next `clk` rise.
- Load-use: exactly 1 stall cycle per hazard occurrence.
- Branch: 2 bubbles (IF/ID and ID/EX) in the redirect cycle; no stall.
- mul/div with `mdu_start` first seen at cycle t: freeze in cycles t..t+MDU_LAT-2 (MDU_LAT-1 cycles), advance at cycle t+MDU_LAT-1.
- Halt: freeze pattern in the detect cycle, HALT from the next cycle. `resume` is honoured in any HALT cycle, including the first, and RUN resumes on the following cycle.
- `resume` outside HALT is ignored.

## Test plan
- Load `lw $8` in EX (`ex_dst`=8), ID reads `rs`=8 -> one cycle with `pc_en`=0, `ifid_en`=0, `idex_clr`=1; `stall_cnt` 0->1. Repeat with `ex_dst`=0 -> no stall.
- `ex_branch_taken`=1 together with a load-use match -> branch wins: `pc_en`=1, `ifid_clr`=`idex_clr`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- MDU_LAT=4, `mdu_start` held high from cycle 10 -> freeze in cycles 10-12, advance in cycle 13; `stall_cnt`=3. Repeat with MDU_LAT=2 -> single freeze in cycle 10.
- `ex_halt` at cycle 5 -> freeze in cycle 5; `halted`=1 and all `en`=0 from cycle 6; `resume` at cycle 9 with `ex_halt` still high -> `exmem_clr`=1 and the front end advances in cycle 9; RUN in cycle 10; `stall_cnt` counts only cycle 5.
- Assert `rst_n`=0 mid-MDU_WAIT (`mcnt`=1) -> immediately all outputs 0 and counters 0; after release the state is RUN with default advance.
- Preload the counters near max using CNT_W=3, then 10 branch flushes -> `flush_cnt` sticks at 7.
